// File: rtl/delay_sequencer.sv
// rtl/delay_sequencer.sv - clear/count/expire sequencer for the 2 kHz game-delay counter
// Optional restart-on-request while busy: define DELAY_SEQ_RETRIGGER_EN.
module delay_sequencer #(
    parameter int PW          = 4,
    parameter int RST_TIMEOUT = 8,
    parameter int TW          = 4
) (
    input  logic          clk_2K,
    input  logic          i_ResetNeg,
    input  logic          i_Req,
    input  logic [PW-1:0] i_Periods,
    input  logic          i_Abort,
    input  logic          i_RstOK,
    input  logic          i_TwoSec,
    output logic          o_RstCounter,
    output logic          o_ActCounter,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Err,
    output logic [PW-1:0] o_PeriodsLeft
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_CLR,
        RUN,
        DONE
    } state_t;

    localparam logic [TW-1:0] TMO_LAST = TW'(RST_TIMEOUT);
    localparam logic [PW-1:0] ONE_PERIOD = PW'(1);

    state_t        state;
    state_t        stateNext;
    logic [PW-1:0] periodsLeft;
    logic [PW-1:0] periodsNext;
    logic          err;
    logic          errNext;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmoNext;
    logic [TW-1:0] tmoInc;
    logic [PW-1:0] loadPeriods;
    logic          retrig;

    // A zero period count still gives one full period of delay.
    assign loadPeriods = (i_Periods == '0) ? ONE_PERIOD : i_Periods;
    assign tmoInc      = tmo + TW'(1);

`ifdef DELAY_SEQ_RETRIGGER_EN
    assign retrig = i_Req && ((state == CLEAR) || (state == WAIT_CLR) || (state == RUN));
`else
    assign retrig = 1'b0;
`endif

    always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
        if (i_ResetNeg) begin
            state       <= IDLE;
            periodsLeft <= '0;
            err         <= 1'b0;
            tmo         <= '0;
        end else begin
            state       <= stateNext;
            periodsLeft <= periodsNext;
            err         <= errNext;
            tmo         <= tmoNext;
        end
    end

    always_comb begin
        stateNext   = state;
        periodsNext = periodsLeft;
        errNext     = err;
        tmoNext     = tmo;
        if (i_Abort && (state != IDLE)) begin
            stateNext   = IDLE;
            periodsNext = '0;
        end else if (retrig) begin
            stateNext   = CLEAR;
            periodsNext = loadPeriods;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Req && !i_Abort) begin
                        stateNext   = CLEAR;
                        periodsNext = loadPeriods;
                        errNext     = 1'b0;
                    end
                end
                CLEAR: begin
                    tmoNext   = '0;
                    stateNext = WAIT_CLR;
                end
                WAIT_CLR: begin
                    // An acknowledge on the timeout edge still counts.
                    if (i_RstOK) begin
                        stateNext = RUN;
                    end else begin
                        tmoNext = tmoInc;
                        if (tmoInc == TMO_LAST) begin
                            stateNext   = IDLE;
                            errNext     = 1'b1;
                            periodsNext = '0;
                        end
                    end
                end
                RUN: begin
                    if (i_TwoSec) begin
                        if (periodsLeft <= ONE_PERIOD) begin
                            stateNext   = DONE;
                            periodsNext = '0;
                        end else begin
                            stateNext   = CLEAR;
                            periodsNext = periodsLeft - ONE_PERIOD;
                        end
                    end
                end
                DONE: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext   = IDLE;
                    periodsNext = '0;
                end
            endcase
        end
    end

    assign o_RstCounter  = (state == CLEAR) || (state == WAIT_CLR);
    assign o_ActCounter  = (state == RUN);
    assign o_Busy        = (state != IDLE);
    assign o_Done        = (state == DONE);
    assign o_Err         = err;
    assign o_PeriodsLeft = periodsLeft;

endmodule

// File: tb/tb_delay_sequencer.sv
// tb/tb_delay_sequencer.sv - table-driven and directed checks for delay_sequencer
`timescale 1ns/1ps
module tb_delay_sequencer;

    logic       clk_2K;
    logic       i_ResetNeg;
    logic       i_Req;
    logic [3:0] i_Periods;
    logic       i_Abort;
    logic       i_RstOK;
    logic       i_TwoSec;
    logic       o_RstCounter;
    logic       o_ActCounter;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Err;
    logic [3:0] o_PeriodsLeft;

    int nChecks = 0;
    int nFail   = 0;
    bit ackEn   = 1'b1;
    int runCnt  = 0;

    typedef struct {
        int periods;
        bit ack;
        int rounds;
        int dones;
        bit err;
        int busy;
    } vec_t;

    vec_t vecs[7];

    delay_sequencer dut (
        .clk_2K       (clk_2K),
        .i_ResetNeg   (i_ResetNeg),
        .i_Req        (i_Req),
        .i_Periods    (i_Periods),
        .i_Abort      (i_Abort),
        .i_RstOK      (i_RstOK),
        .i_TwoSec     (i_TwoSec),
        .o_RstCounter (o_RstCounter),
        .o_ActCounter (o_ActCounter),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Err        (o_Err),
        .o_PeriodsLeft(o_PeriodsLeft)
    );

    initial begin
        clk_2K = 1'b0;
        forever #5 clk_2K = ~clk_2K;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock plus the bench's model of the counter: ack follows clear, expiry after 5 RUN cycles.
    task automatic step();
        @(posedge clk_2K);
        #1;
        i_RstOK = ackEn && o_RstCounter;
        if (o_ActCounter) runCnt++;
        else runCnt = 0;
        i_TwoSec = (runCnt == 5);
    endtask

    task automatic waitIdle(input int pEff, output int dones, output int busyCyc,
                            output int rounds, output int rstCyc);
        bit prevRst;
        int n;
        dones = 0; busyCyc = 0; rounds = 0; rstCyc = 0; prevRst = 1'b0; n = 0;
        while (o_Busy && n < 300) begin
            busyCyc++;
            if (o_Done) dones++;
            if (o_RstCounter) rstCyc++;
            if (o_RstCounter && !prevRst) begin
                rounds++;
                if (pEff > 0) chk("roundPeriodsLeft", int'(o_PeriodsLeft), pEff - rounds + 1);
            end
            prevRst = o_RstCounter;
            step();
            n++;
        end
        chk("idleReached", int'(o_Busy), 0);
    endtask

    task automatic waitAct();
        int n;
        n = 0;
        while (!o_ActCounter && n < 50) begin
            step();
            n++;
        end
        chk("runReached", int'(o_ActCounter), 1);
    endtask

    initial begin
        int dones, busyCyc, rounds, rstCyc, p, pEff;

        vecs[0] = '{periods: 1,  ack: 1'b1, rounds: 1,  dones: 1, err: 1'b0, busy: 8};
        vecs[1] = '{periods: 3,  ack: 1'b1, rounds: 3,  dones: 1, err: 1'b0, busy: 22};
        vecs[2] = '{periods: 0,  ack: 1'b1, rounds: 1,  dones: 1, err: 1'b0, busy: 8};
        vecs[3] = '{periods: 1,  ack: 1'b0, rounds: 1,  dones: 0, err: 1'b1, busy: 9};
        vecs[4] = '{periods: 2,  ack: 1'b1, rounds: 2,  dones: 1, err: 1'b0, busy: 15};
        vecs[5] = '{periods: 5,  ack: 1'b0, rounds: 1,  dones: 0, err: 1'b1, busy: 9};
        vecs[6] = '{periods: 15, ack: 1'b1, rounds: 15, dones: 1, err: 1'b0, busy: 106};

        i_ResetNeg = 1'b1; i_Req = 1'b0; i_Periods = '0; i_Abort = 1'b0;
        i_RstOK = 1'b0; i_TwoSec = 1'b0;
        step();
        step();
        chk("rstBusy", int'(o_Busy), 0);
        chk("rstRstCounter", int'(o_RstCounter), 0);
        chk("rstActCounter", int'(o_ActCounter), 0);
        chk("rstDone", int'(o_Done), 0);
        chk("rstErr", int'(o_Err), 0);
        chk("rstPeriodsLeft", int'(o_PeriodsLeft), 0);
        i_ResetNeg = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            p     = vecs[i].periods;
            pEff  = (p == 0) ? 1 : p;
            ackEn = vecs[i].ack;
            i_Periods = 4'(p);
            i_Req = 1'b1;
            step();
            i_Req = 1'b0;
            chk("reqBusy", int'(o_Busy), 1);
            chk("reqRstCounter", int'(o_RstCounter), 1);
            chk("reqErrCleared", int'(o_Err), 0);
            waitIdle(pEff, dones, busyCyc, rounds, rstCyc);
            chk("vecRounds", rounds, vecs[i].rounds);
            chk("vecDones", dones, vecs[i].dones);
            chk("vecBusyCycles", busyCyc, vecs[i].busy);
            chk("vecRstCycles", rstCyc, vecs[i].ack ? 2 * vecs[i].rounds : 9);
            chk("vecErr", int'(o_Err), int'(vecs[i].err));
            chk("vecPeriodsLeft", int'(o_PeriodsLeft), 0);
            chk("vecActIdle", int'(o_ActCounter), 0);
            step();
        end

        // Abort in RUN with two periods left, request on the same edge.
        ackEn = 1'b1;
        i_Periods = 4'd3;
        i_Req = 1'b1;
        step();
        i_Req = 1'b0;
        begin
            int n;
            n = 0;
            while (!(o_ActCounter && o_PeriodsLeft == 4'd2) && n < 100) begin
                step();
                n++;
            end
        end
        chk("abortSetup", int'(o_PeriodsLeft), 2);
        i_Abort = 1'b1;
        i_Req = 1'b1;
        step();
        i_Abort = 1'b0;
        i_Req = 1'b0;
        chk("abortBusy", int'(o_Busy), 0);
        chk("abortAct", int'(o_ActCounter), 0);
        chk("abortRst", int'(o_RstCounter), 0);
        chk("abortPeriodsLeft", int'(o_PeriodsLeft), 0);
        chk("abortDone", int'(o_Done), 0);
        chk("abortErr", int'(o_Err), 0);
        step();
        chk("abortReqIgnored", int'(o_Busy), 0);

        // Abort together with request in IDLE drops the request.
        i_Periods = 4'd1;
        i_Abort = 1'b1;
        i_Req = 1'b1;
        step();
        i_Abort = 1'b0;
        i_Req = 1'b0;
        chk("idleAbortReqBusy", int'(o_Busy), 0);
        chk("idleAbortReqPeriods", int'(o_PeriodsLeft), 0);

        // Acknowledge arriving on the timeout edge wins.
        ackEn = 1'b0;
        i_Req = 1'b1;
        step();
        i_Req = 1'b0;
        repeat (8) step();
        chk("tieStillWaiting", int'(o_RstCounter), 1);
        i_RstOK = 1'b1;
        step();
        chk("tieRun", int'(o_ActCounter), 1);
        chk("tieNoErr", int'(o_Err), 0);
        ackEn = 1'b1;
        waitIdle(0, dones, busyCyc, rounds, rstCyc);
        chk("tieDone", dones, 1);

        // Asynchronous reset between edges while in RUN.
        i_Periods = 4'd2;
        i_Req = 1'b1;
        step();
        i_Req = 1'b0;
        waitAct();
        #2;
        i_ResetNeg = 1'b1;
        #1;
        chk("asyncRstBusy", int'(o_Busy), 0);
        chk("asyncRstAct", int'(o_ActCounter), 0);
        chk("asyncRstRst", int'(o_RstCounter), 0);
        chk("asyncRstDone", int'(o_Done), 0);
        chk("asyncRstPeriods", int'(o_PeriodsLeft), 0);
        #1;
        i_ResetNeg = 1'b0;
        step();
        chk("postRstIdle", int'(o_Busy), 0);

        // Request while in RUN.
        i_Periods = 4'd1;
        i_Req = 1'b1;
        step();
        i_Req = 1'b0;
        waitAct();
        step();
        step();
        i_Periods = 4'd2;
        i_Req = 1'b1;
        step();
        i_Req = 1'b0;
`ifdef DELAY_SEQ_RETRIGGER_EN
        chk("retrigPeriods", int'(o_PeriodsLeft), 2);
        chk("retrigClear", int'(o_RstCounter), 1);
        waitIdle(2, dones, busyCyc, rounds, rstCyc);
        chk("retrigRounds", rounds, 2);
        chk("retrigDones", dones, 1);
`else
        chk("busyReqPeriods", int'(o_PeriodsLeft), 1);
        chk("busyReqStillRun", int'(o_ActCounter), 1);
        waitIdle(0, dones, busyCyc, rounds, rstCyc);
        chk("busyReqDones", dones, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
